// File: rtl/fifo_byte_packer.sv
// Packs ratio consecutive FIFO entries into one registered output word.
// Optional early partial-word flush: define FIFO_BYTE_PACKER_FLUSH_EN.
module fifo_byte_packer #(
  parameter int width = 8,
  parameter int ratio = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   empty,
  input  logic [width-1:0]       read_data,
  output logic                   pop,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef FIFO_BYTE_PACKER_FLUSH_EN
  input  logic                   flush,
`endif
  output logic [width*ratio-1:0] out_data
);

  localparam int cw = (ratio > 2) ? $clog2(ratio) : 1;
  localparam logic [cw-1:0] last = cw'(ratio - 1);

  logic [cw-1:0]                cnt;
  logic [ratio-2:0][width-1:0]  partial;
  logic                         full;
  logic                         free;
  logic                         take;

  assign full = (cnt == last);
  assign free = ~out_valid | out_ready;

`ifdef FIFO_BYTE_PACKER_FLUSH_EN
  logic                   flush_go;
  logic [width*ratio-1:0] flush_word;

  assign flush_go = flush & (cnt != '0) & free;
  assign take     = ~flush;

  // Buffered entries go in the low slots, everything above is zero.
  always_comb begin
    flush_word = '0;
    for (int i = 0; i < ratio - 1; i++) begin
      if (i < int'(cnt)) begin
        flush_word[i*width +: width] = partial[i];
      end
    end
  end
`else
  assign take = 1'b1;
`endif

  assign pop = rst & take & ~empty & (~full | free);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      partial   <= '0;
    end else begin
      if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (pop) begin
        if (full) begin
          out_data  <= {read_data, partial};
          out_valid <= 1'b1;
          cnt       <= '0;
        end else begin
          partial[cnt] <= read_data;
          cnt          <= cnt + cw'(1);
        end
      end
`ifdef FIFO_BYTE_PACKER_FLUSH_EN
      if (flush_go) begin
        out_data  <= flush_word;
        out_valid <= 1'b1;
        cnt       <= '0;
      end
`endif
    end
  end

endmodule
